alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter XLEN, default 32, operand/result width.
REQ-002 Parameter OPW, default 17, full_op width {func7[16:10], func3[9:7], opcode[6:0]}.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0_valid / req1_valid  input  1 each  requester k presents an operation.
REQ-006 req0_ready / req1_ready  output  1 each  arbiter accepts requester k this cycle.
REQ-007 req0_op / req1_op  input  OPW each  full_op of requester k.
REQ-008 req0_in1, req0_in2 / req1_in1, req1_in2  input  XLEN each  operands of requester k.
REQ-009 rsp0_valid / rsp1_valid  output  1 each  result available for requester k.
REQ-010 rsp0_ready / rsp1_ready  input  1 each  requester k consumes result.
REQ-011 rsp_data  output  XLEN  shared result bus, meaningful only while a rsp*_valid is high.
REQ-012 busy  output  1  high while a result is held (state HOLD).

Function
REQ-013 Shall time-share one instance of the team's combinational ALU between two requesters.
REQ-014 FSM states: IDLE (no result held), HOLD (result held for owner requester).
REQ-015 Request transfer when reqk_valid && reqk_ready; response transfer when rspk_valid && rspk_ready.
REQ-016 reqk_ready shall be high only for the granted requester, only when its reqk_valid is high, and only in IDLE or in HOLD during the cycle the held response transfers.
REQ-017 Arbitration round-robin: single request granted directly; both valid -> grant the requester not granted last; last_grant updates on every request transfer.
REQ-018 On request transfer, op, in1, in2 and owner id shall be registered; ALU inputs come only from these registers.
REQ-019 Latency: request transfer in cycle N -> rsp_owner_valid high from cycle N+1, rsp_data = ALU(registered op, in1, in2).
REQ-020 rspk_valid, rsp_data and owner shall stay stable until the response transfers; the non-owner's rsp_valid stays 0.
REQ-021 HOLD + response transfer + new request transfer in same cycle -> remain HOLD with new operands (throughput one op per cycle).
REQ-022 HOLD + response transfer, no request -> IDLE next cycle.
REQ-023 HOLD without rspk_ready -> no request accepted, both reqk_ready low (backpressure).
REQ-024 Operations the ALU defines as illegal pass through unchanged; the arbiter does no opcode checking.
REQ-025 reqk_valid dropping without transfer shall have no effect; no request is latched without handshake.

Reset
REQ-026 rst_n low shall immediately force: state IDLE, rsp0_valid=0, rsp1_valid=0, req0_ready=0, req1_ready=0, busy=0, operand/op registers=0, last_grant=1 (requester 0 wins first tie).
REQ-027 Reset during HOLD discards the held result; no response is issued after release.
REQ-028 First request transfer possible in the first clock edge after rst_n deasserts.

Structure
REQ-029 Shared package holds XLEN, OPW, the FSM state encoding and the full_op field positions used by benches to build ops.
REQ-030 One sub-module: alu (existing combinational ALU, ports in1, in2, full_op, out), instantiated once.
REQ-031 Arbitration/FSM logic lives in alu_arbiter itself; no further sub-modules.

Verification
REQ-032 Req0 only: op=17'h00033, in1=32'hff, in2=32'hff00, rsp0_ready=1 -> rsp0_valid next cycle, rsp_data=32'h0000ffff, rsp1_valid=0.
REQ-033 Both valid same cycle after reset: req0 sub 17'h08033 ff/cc, req1 and 17'h003b3 00ff00ff/ff0000ff -> req0 served first (32'h33), then req1 (32'h000000ff).
REQ-034 Both continuously valid, responses always ready, 8 cycles -> grants alternate 0,1,0,1..., one response per cycle, no gaps.
REQ-035 Req1 slt 17'h00133 in1=-10, in2=-1, rsp1_ready low 3 cycles -> rsp1_valid, rsp_data=1 held stable 3 cycles, req0_ready=0 meanwhile, busy=1.
REQ-036 Req0 sll 17'h000b3 ff/4 accepted, rst_n pulsed low while HOLD -> all valids 0 asynchronously, no 32'hff0 response after release.
REQ-037 Req0 valid pulsed 1 cycle while HOLD blocked by rsp1_ready=0 -> request never accepted, no rsp0_valid.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// alu_arbiter_pkg
// Shared definitions for the two-requester ALU arbiter:
//   - default operand width (ALU_XLEN) and full_op width (ALU_OPW)
//   - full_op field positions {func7[16:10], func3[9:7], opcode[6:0]}
//   - R-type opcode / func encodings understood by the ALU
//   - arbiter FSM state encoding
//   - makeOp() helper so benches can build full_op values from fields
// ---------------------------------------------------------------------------
package alu_arbiter_pkg;

  localparam int ALU_XLEN = 32;
  localparam int ALU_OPW  = 17;

  // Field positions inside full_op
  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_W   = 7;
  localparam int FUNC3_LSB  = 7;
  localparam int FUNC3_W    = 3;
  localparam int FUNC7_LSB  = 10;
  localparam int FUNC7_W    = 7;

  localparam logic [OPCODE_W-1:0] OPC_OP = 7'h33;

  localparam logic [FUNC3_W-1:0] F3_ADD_SUB = 3'd0;
  localparam logic [FUNC3_W-1:0] F3_SLL     = 3'd1;
  localparam logic [FUNC3_W-1:0] F3_SLT     = 3'd2;
  localparam logic [FUNC3_W-1:0] F3_SLTU    = 3'd3;
  localparam logic [FUNC3_W-1:0] F3_XOR     = 3'd4;
  localparam logic [FUNC3_W-1:0] F3_SRL_SRA = 3'd5;
  localparam logic [FUNC3_W-1:0] F3_OR      = 3'd6;
  localparam logic [FUNC3_W-1:0] F3_AND     = 3'd7;

  localparam logic [FUNC7_W-1:0] F7_BASE = 7'h00;
  localparam logic [FUNC7_W-1:0] F7_ALT  = 7'h20;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arbState_e;

  function automatic logic [ALU_OPW-1:0] makeOp(
    input logic [FUNC7_W-1:0]  func7,
    input logic [FUNC3_W-1:0]  func3,
    input logic [OPCODE_W-1:0] opcode
  );
    return {func7, func3, opcode};
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// ---------------------------------------------------------------------------
// alu
// Combinational integer ALU for R-type operations (opcode 7'h33).
// Any opcode/func combination it does not recognise is illegal and yields 0.
// Ports:
//   in1, in2  operands (XLEN)
//   full_op   {func7, func3, opcode} (OPW)
//   out       result (XLEN)
// ---------------------------------------------------------------------------
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int XLEN = ALU_XLEN,
  parameter int OPW  = ALU_OPW
) (
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic [OPW-1:0]  full_op,
  output logic [XLEN-1:0] out
);

  localparam int SHW = $clog2(XLEN);

  logic [FUNC7_W-1:0]  func7;
  logic [FUNC3_W-1:0]  func3;
  logic [OPCODE_W-1:0] opcode;
  logic [SHW-1:0]      shamt;

  assign func7  = full_op[FUNC7_LSB +: FUNC7_W];
  assign func3  = full_op[FUNC3_LSB +: FUNC3_W];
  assign opcode = full_op[OPCODE_LSB +: OPCODE_W];
  assign shamt  = in2[SHW-1:0];

  // Decode {func7, func3} for R-type ops; everything else falls to 0
  always_comb begin
    out = '0;
    if (opcode == OPC_OP) begin
      case ({func7, func3})
        {F7_BASE, F3_ADD_SUB}: out = in1 + in2;
        {F7_ALT,  F3_ADD_SUB}: out = in1 - in2;
        {F7_BASE, F3_SLL}:     out = in1 << shamt;
        {F7_BASE, F3_SLT}:     out = XLEN'($signed(in1) < $signed(in2));
        {F7_BASE, F3_SLTU}:    out = XLEN'(in1 < in2);
        {F7_BASE, F3_XOR}:     out = in1 ^ in2;
        {F7_BASE, F3_SRL_SRA}: out = in1 >> shamt;
        {F7_ALT,  F3_SRL_SRA}: out = $signed(in1) >>> shamt;
        {F7_BASE, F3_OR}:      out = in1 | in2;
        {F7_BASE, F3_AND}:     out = in1 & in2;
        default:               out = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Time-shares one combinational ALU between two requesters with valid/ready
// handshakes. A granted request is registered; its result is presented on the
// shared rsp_data bus from the next cycle and held until the owner accepts it.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   reqK_valid/ready/op/in1/in2    request channel of requester K (K=0,1)
//   rspK_valid/ready               response channel of requester K
//   rsp_data                       shared result bus
//   busy                           high while a result is held
// ---------------------------------------------------------------------------
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int XLEN = ALU_XLEN,
  parameter int OPW  = ALU_OPW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OPW-1:0]  req0_op,
  input  logic [XLEN-1:0] req0_in1,
  input  logic [XLEN-1:0] req0_in2,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OPW-1:0]  req1_op,
  input  logic [XLEN-1:0] req1_in1,
  input  logic [XLEN-1:0] req1_in2,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            busy
);

  arbState_e       state_q;
  logic            owner_q;
  logic            lastGrant_q;
  logic [OPW-1:0]  op_q;
  logic [XLEN-1:0] in1_q;
  logic [XLEN-1:0] in2_q;
  logic            rsp0Valid_q;
  logic            rsp1Valid_q;
  logic            busy_q;

  logic            rspFire;
  logic            canAccept;
  logic            grantSel;
  logic            reqFire;
  logic [OPW-1:0]  op_d;
  logic [XLEN-1:0] in1_d;
  logic [XLEN-1:0] in2_d;

  // Grant and handshake decisions. A new request may only be taken when no
  // result is held, or when the held result leaves in this very cycle, which
  // gives back-to-back throughput. Reset gates acceptance immediately.
  always_comb begin
    rspFire   = (state_q == HOLD) && (owner_q ? rsp1_ready : rsp0_ready);
    canAccept = rst_n && ((state_q == IDLE) || rspFire);
    if (req0_valid && req1_valid) begin
      grantSel = ~lastGrant_q;
    end else begin
      grantSel = req1_valid;
    end
    reqFire = canAccept && (req0_valid || req1_valid);
    op_d    = grantSel ? req1_op  : req0_op;
    in1_d   = grantSel ? req1_in1 : req0_in1;
    in2_d   = grantSel ? req1_in2 : req0_in2;
  end

  assign req0_ready = canAccept && req0_valid && !grantSel;
  assign req1_ready = canAccept && req1_valid &&  grantSel;

  // Single FSM process: latches the winning request and keeps the response
  // valids and busy as registered outputs alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      lastGrant_q <= 1'b1;
      op_q        <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      rsp0Valid_q <= 1'b0;
      rsp1Valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (reqFire) begin
      state_q     <= HOLD;
      owner_q     <= grantSel;
      lastGrant_q <= grantSel;
      op_q        <= op_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      rsp0Valid_q <= !grantSel;
      rsp1Valid_q <= grantSel;
      busy_q      <= 1'b1;
    end else if (rspFire) begin
      state_q     <= IDLE;
      rsp0Valid_q <= 1'b0;
      rsp1Valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end
  end

  assign rsp0_valid = rsp0Valid_q;
  assign rsp1_valid = rsp1Valid_q;
  assign busy       = busy_q;

  alu #(
    .XLEN(XLEN),
    .OPW (OPW)
  ) uAlu (
    .in1    (in1_q),
    .in2    (in2_q),
    .full_op(op_q),
    .out    (rsp_data)
  );

endmodule
